// File: rtl/mod_mul_radix4_seq.sv
// Sequential modular multiplier, MSB-first radix-4 interleaved.
// acc = (4*acc + d*B) mod Q per 2-bit digit of A.
module mod_mul_radix4_seq #(
  parameter int BITWIDTH = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iStart,
  input  logic [BITWIDTH-1:0] iA,
  input  logic [BITWIDTH-1:0] iB,
  input  logic [BITWIDTH-1:0] iQ,
  output logic                oReady,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oData
);

  localparam int NDIGIT = BITWIDTH / 2;
  localparam int CW = $clog2(NDIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIGIT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  logic [BITWIDTH-1:0] aReg;
  logic [BITWIDTH-1:0] bReg;
  logic [BITWIDTH-1:0] qReg;
  logic [BITWIDTH-1:0] accReg;
  logic [CW-1:0] cnt;

  logic [1:0] dig;
  logic [BITWIDTH:0] qExt;
  logic [BITWIDTH:0] bExt;
  logic [BITWIDTH:0] s1;
  logic [BITWIDTH:0] r1;
  logic [BITWIDTH:0] s2;
  logic [BITWIDTH:0] r2;
  logic [BITWIDTH:0] s3;
  logic [BITWIDTH:0] r3;
  logic [BITWIDTH:0] s4;
  logic [BITWIDTH-1:0] accNext;

  // One extra bit keeps 2*t and t+B exact before each reduction.
  always_comb begin
    dig = aReg[BITWIDTH-1 -: 2];
    qExt = {1'b0, qReg};
    bExt = {1'b0, bReg};
    s1 = {accReg, 1'b0};
    r1 = (s1 >= qExt) ? s1 - qExt : s1;
    s2 = r1 + (dig[1] ? bExt : '0);
    r2 = (s2 >= qExt) ? s2 - qExt : s2;
    s3 = r2 << 1;
    r3 = (s3 >= qExt) ? s3 - qExt : s3;
    s4 = r3 + (dig[0] ? bExt : '0);
    accNext = BITWIDTH'((s4 >= qExt) ? s4 - qExt : s4);
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      state  <= IDLE;
      aReg   <= '0;
      bReg   <= '0;
      qReg   <= '0;
      accReg <= '0;
      cnt    <= '0;
      oData  <= '0;
      oValid <= 1'b0;
      oReady <= 1'b1;
    end else if (iEn) begin
      unique case (state)
        IDLE: begin
          oValid <= 1'b0;
          if (iStart) begin
            aReg   <= iA;
            bReg   <= iB;
            qReg   <= iQ;
            accReg <= '0;
            cnt    <= '0;
            state  <= RUN;
            oReady <= 1'b0;
          end
        end
        RUN: begin
          aReg   <= {aReg[BITWIDTH-3:0], 2'b00};
          accReg <= accNext;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            oData  <= accNext;
            oValid <= 1'b1;
            oReady <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_radix4_seq.sv
// Bench for mod_mul_radix4_seq: directed literals plus
// randomized traffic against a (A*B)%Q transaction model.
module tb_mod_mul_radix4_seq;

  localparam int W = 16;
  localparam int ND = W / 2;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic iEn = 1'b1;
  logic iClr = 1'b0;
  logic iStart = 1'b0;
  logic [W-1:0] iA = '0;
  logic [W-1:0] iB = '0;
  logic [W-1:0] iQ = 16'd2;
  logic oReady;
  logic oValid;
  logic [W-1:0] oData;

  int nAssert = 0;
  int nFail = 0;
  int nDone = 0;
  bit chkOn = 1'b0;

  bit mBusy = 1'b0;
  bit mValid = 1'b0;
  int mLeft = 0;
  longint unsigned mExp = 0;
  longint unsigned mData = 0;

  mod_mul_radix4_seq #(.BITWIDTH(W)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iEn(iEn),
    .iClr(iClr),
    .iStart(iStart),
    .iA(iA),
    .iB(iB),
    .iQ(iQ),
    .oReady(oReady),
    .oValid(oValid),
    .oData(oData)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Transaction model: a start is taken when idle and enabled,
  // the product appears after ND further enabled edges.
  always @(posedge iClk) begin
    if (iRst || iClr) begin
      mBusy = 1'b0;
      mValid = 1'b0;
      mLeft = 0;
      mData = 0;
    end else if (iEn) begin
      if (!mBusy) begin
        mValid = 1'b0;
        if (iStart) begin
          mBusy = 1'b1;
          mLeft = ND;
          mExp = (longint'(iA) * longint'(iB)) % longint'(iQ);
        end
      end else begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 1'b0;
          mValid = 1'b1;
          mData = mExp;
          nDone++;
        end
      end
    end
  end

  always @(negedge iClk) begin
    if (chkOn) begin
      check("model ready", {63'd0, oReady}, {63'd0, !mBusy});
      check("model valid", {63'd0, oValid}, {63'd0, mValid});
      check("model data", {48'd0, oData}, mData);
    end
  end

  task automatic startOp(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [W-1:0] q);
    int n;
    n = 0;
    @(negedge iClk);
    while (!oReady && n < 60) begin
      @(negedge iClk);
      n++;
    end
    if (!oReady) check("ready timeout", 0, 1);
    iA = a;
    iB = b;
    iQ = q;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    do begin
      @(negedge iClk);
      n++;
    end while (!oValid && n < 60);
    if (!oValid) check("valid timeout", 0, 1);
  endtask

  task automatic runOp(input string name,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] q,
                       input logic [W-1:0] exp);
    int n;
    startOp(a, b, q);
    check({name, " busy"}, {63'd0, oReady}, 0);
    waitValid(n);
    check({name, " latency"}, n, ND);
    check({name, " data"}, {48'd0, oData}, {48'd0, exp});
  endtask

  task automatic abortOp(input bit useRst);
    int seen;
    startOp(16'd1234, 16'd5678, 16'd12289);
    repeat (4) @(negedge iClk);
    if (useRst) iRst = 1'b1;
    else iClr = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    iClr = 1'b0;
    check("abort ready", {63'd0, oReady}, 1);
    check("abort valid", {63'd0, oValid}, 0);
    check("abort data", {48'd0, oData}, 0);
    seen = 0;
    repeat (15) begin
      @(negedge iClk);
      if (oValid) seen++;
    end
    check("abort no valid", seen, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n2;
    logic [W-1:0] q;
    repeat (2) @(negedge iClk);
    check("reset ready", {63'd0, oReady}, 1);
    check("reset valid", {63'd0, oValid}, 0);
    check("reset data", {48'd0, oData}, 0);
    iRst = 1'b0;
    chkOn = 1'b1;

    runOp("basic", 16'd1234, 16'd5678, 16'd12289, 16'd1922);
    runOp("q-1 sq", 16'd12288, 16'd12288, 16'd12289, 16'd1);
    runOp("big q", 16'd65520, 16'd2, 16'd65521, 16'd65519);
    runOp("a zero", 16'd0, 16'd777, 16'd12289, 16'd0);
    runOp("a one", 16'd1, 16'd777, 16'd12289, 16'd777);

    startOp(16'd1234, 16'd5678, 16'd12289);
    iA = 16'hBEEF;
    iB = 16'd3;
    iQ = 16'd500;
    waitValid(n);
    check("b2b first data", {48'd0, oData}, 1922);
    check("b2b ready", {63'd0, oReady}, 1);
    iA = 16'd2;
    iB = 16'd3;
    iQ = 16'd12289;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    waitValid(n);
    check("b2b gap", n + 1, ND + 1);
    check("b2b second data", {48'd0, oData}, 6);

    startOp(16'd1234, 16'd5678, 16'd12289);
    repeat (3) @(negedge iClk);
    iEn = 1'b0;
    repeat (3) @(negedge iClk);
    iEn = 1'b1;
    waitValid(n2);
    check("stall latency", 6 + n2, ND + 3);
    check("stall data", {48'd0, oData}, 1922);
    iEn = 1'b0;
    repeat (3) begin
      @(negedge iClk);
      check("stall hold valid", {63'd0, oValid}, 1);
    end
    iEn = 1'b1;
    @(negedge iClk);
    check("stall valid drop", {63'd0, oValid}, 0);

    abortOp(1'b0);
    abortOp(1'b1);
    runOp("after abort", 16'd1234, 16'd5678, 16'd12289, 16'd1922);

    for (int c = 0; c < 40000; c++) begin
      @(negedge iClk);
      iEn = ($urandom_range(0, 5) != 0);
      iClr = ($urandom_range(0, 999) == 0);
      iStart = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0)
        q = W'(16'd65535 - W'($urandom_range(0, 15)));
      else
        q = W'($urandom_range(2, 65535));
      iQ = q;
      iA = W'($urandom % q);
      iB = W'($urandom % q);
    end
    @(negedge iClk);
    iEn = 1'b1;
    iClr = 1'b0;
    iStart = 1'b0;
    repeat (12) @(negedge iClk);
    check("random txn count", {63'd0, nDone > 1000}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
